systolic_output_deskew: RTL and testbench

//   Output-side counterpart of the row-skew input registers. Sits on the south edge of the

---
 rtl/systolic_output_deskew_pkg.sv | 20 ++
 rtl/systolic_output_deskew_fifo.sv | 79 +++++++
 rtl/systolic_output_deskew.sv | 147 ++++++++++++++
 tb/tb_systolic_output_deskew.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_output_deskew_pkg.sv
// Shared definitions for the systolic output deskew block.
//   DATA_W        : width of one array column result lane
//   deskew_state_e: frame-tracking FSM states
//   lane_lsb()    : LSB of column c inside a COL-lane bus. Column 0 occupies the
//                   most-significant lane, i.e. col c -> [(COL-c)*DATA_W-1 -: DATA_W]
package systolic_output_deskew_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } deskew_state_e;

  function automatic int unsigned lane_lsb(input int unsigned cols, input int unsigned c);
    return (cols - 1 - c) * DATA_W;
  endfunction

endpackage

// File: rtl/systolic_output_deskew_fifo.sv
// deskew_fifo: synchronous FIFO holding aligned result rows.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write request and row; ignored when full unless a pop frees a slot
//   pop_i        : read request; ignored when empty
//   data_o       : registered head entry; holds the last head while empty
//   empty_o      : no entries stored
//   full_o       : DEPTH entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
module deskew_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rd_next = rd_ptr_q + PTR_W'(1);
  assign data_o  = head_q;

  // The head is kept in its own register so the output is purely registered
  // and keeps its last value once the FIFO runs dry.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = do_pop ? rd_next : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    head_d   = head_q;
    if (do_pop) begin
      if (count_q > CNT_W'(1)) begin
        head_d = mem_q[rd_next];
      end else if (do_push) begin
        head_d = data_i;
      end
    end else if (empty_o && do_push) begin
      head_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: removes the per-column skew of results leaving the
// south edge of the systolic array, buffers aligned rows and frames ROW rows
// per tile.
//   in_clk, in_rst : clock, synchronous active-high reset
//   in_south       : skewed column results, col c in [(COL-c)*32-1 -: 32]
//   in_valid       : col 0 valid now; col c valid c cycles later
//   in_ready       : downstream accepts out_data this cycle
//   out_data       : aligned row (registered FIFO head), same lane order
//   out_valid      : FIFO not empty
//   out_frame_done : one-cycle pulse when a tile has been fully handed off
//   out_busy       : frame FSM not idle
//   out_overflow   : sticky, an aligned row was dropped on a full FIFO
module systolic_output_deskew
  import systolic_output_deskew_pkg::*;
#(
  parameter int unsigned ROW        = 9,
  parameter int unsigned COL        = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [COL*DATA_W-1:0] in_south,
  input  logic                  in_valid,
  input  logic                  in_ready,
  output logic [COL*DATA_W-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_frame_done,
  output logic                  out_busy,
  output logic                  out_overflow
);

  localparam int unsigned ROW_W = $clog2(ROW + 1);

  logic [COL*DATA_W-1:0] aligned_row;
  logic [COL-2:0]        vpipe_q;
  logic                  aligned_valid;
  logic                  fifo_empty, fifo_full;
  logic                  pop, drop;

  deskew_state_e         state_q, state_d;
  logic [ROW_W-1:0]      push_cnt_q, push_cnt_d;
  logic [ROW_W-1:0]      pop_cnt_q, pop_cnt_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q;

  // Column c is delayed COL-1-c cycles so every lane lines up with the last column.
  for (genvar c = 0; c < COL; c++) begin : g_lane
    localparam int unsigned LSB  = lane_lsb(COL, c);
    localparam int unsigned NREG = COL - 1 - c;
    if (NREG == 0) begin : g_pass
      assign aligned_row[LSB +: DATA_W] = in_south[LSB +: DATA_W];
    end else begin : g_dly
      logic [DATA_W-1:0] dly_q [NREG];
      always_ff @(posedge in_clk) begin
        if (in_rst) begin
          for (int unsigned i = 0; i < NREG; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= in_south[LSB +: DATA_W];
          for (int unsigned i = 1; i < NREG; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign aligned_row[LSB +: DATA_W] = dly_q[NREG-1];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= in_valid;
      for (int unsigned i = 1; i < COL - 1; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end

  assign aligned_valid = vpipe_q[COL-2];
  assign pop           = ~fifo_empty & in_ready;
  assign drop          = aligned_valid & fifo_full & ~pop;

  deskew_fifo #(
    .WIDTH (COL * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (in_clk),
    .rst_i   (in_rst),
    .push_i  (aligned_valid),
    .data_i  (aligned_row),
    .pop_i   (pop),
    .data_o  (out_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Dropped rows still count as pushed, so a tile that lost rows can only end
  // once nothing is left buffered or in flight.
  always_comb begin
    state_d      = state_q;
    push_cnt_d   = push_cnt_q;
    pop_cnt_d    = pop_cnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_FILL;
          push_cnt_d = '0;
          pop_cnt_d  = '0;
        end
      end
      ST_FILL: begin
        if (aligned_valid) begin
          if (push_cnt_q == ROW_W'(ROW - 1)) state_d = ST_DRAIN;
          if (push_cnt_q != ROW_W'(ROW)) push_cnt_d = push_cnt_q + ROW_W'(1);
        end
        if (pop && pop_cnt_q != ROW_W'(ROW)) pop_cnt_d = pop_cnt_q + ROW_W'(1);
      end
      ST_DRAIN: begin
        if (pop && pop_cnt_q != ROW_W'(ROW)) pop_cnt_d = pop_cnt_q + ROW_W'(1);
        if ((pop && pop_cnt_q == ROW_W'(ROW - 1)) || (fifo_empty && vpipe_q == '0)) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      push_cnt_q   <= '0;
      pop_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      push_cnt_q   <= push_cnt_d;
      pop_cnt_q    <= pop_cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_q | drop;
    end
  end

  assign out_valid      = ~fifo_empty;
  assign out_frame_done = frame_done_q;
  assign out_busy       = (state_q != ST_IDLE);
  assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Self-checking bench for systolic_output_deskew (COL=4, ROW=3, FIFO_DEPTH=2).
// A queue-level model of the block is compared against the outputs every cycle,
// and a few literal expectations pin down the model at key points.
module tb_systolic_output_deskew;

  localparam int COL   = 4;
  localparam int ROW   = 3;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int W     = COL * DW;
  localparam int HMAX  = 4096;

  logic         in_clk = 1'b0;
  logic         in_rst;
  logic [W-1:0] in_south;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_frame_done;
  logic         out_busy;
  logic         out_overflow;

  systolic_output_deskew #(
    .ROW        (ROW),
    .COL        (COL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .in_clk         (in_clk),
    .in_rst         (in_rst),
    .in_south       (in_south),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_frame_done (out_frame_done),
    .out_busy       (out_busy),
    .out_overflow   (out_overflow)
  );

  always #5 in_clk = ~in_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         hv [HMAX];
  logic [W-1:0] hd [HMAX];
  int           cyc = 0;
  int           last_rst = -1;
  bit           model_live = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] shown;
  bit           active, filled;
  int           pushes, pops;
  logic         exp_valid, exp_busy, exp_ov, exp_fd;

  always @(posedge in_clk) begin : model
    int           j;
    bit           push, pop, pend, ended;
    logic [W-1:0] row;
    if (cyc >= HMAX - 1) begin
      $display("FAIL history: bench ran past %0d cycles", HMAX);
      $fatal(1);
    end
    hv[cyc] = in_valid;
    hd[cyc] = in_south;
    if (in_rst) begin
      q.delete();
      shown = '0; active = 0; filled = 0; pushes = 0; pops = 0;
      exp_valid = 0; exp_busy = 0; exp_ov = 0; exp_fd = 0;
      last_rst = cyc;
      model_live = 1;
    end else if (model_live) begin
      // Row whose column 0 arrived COL-1 cycles ago is complete now.
      j    = cyc - (COL - 1);
      push = (j > last_rst) && hv[j];
      row  = '0;
      if (push)
        for (int c = 0; c < COL; c++)
          row[(COL-1-c)*DW +: DW] = hd[j+c][(COL-1-c)*DW +: DW];
      pend = 0;
      for (int k = 1; k < COL; k++)
        if ((cyc - k > last_rst) && hv[cyc-k]) pend = 1;
      pop   = (q.size() > 0) && in_ready;
      ended = active && filled && ((pop && pops == ROW - 1) || (q.size() == 0 && !pend));
      if (active && !filled && push) begin
        pushes++;
        if (pushes == ROW) filled = 1;
      end
      if (active && pop && pops < ROW) pops++;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(row);
        else exp_ov = 1;
      end
      if (q.size() > 0) shown = q[0];
      if (ended) active = 0;
      else if (!active && in_valid) begin
        active = 1; filled = 0; pushes = 0; pops = 0;
      end
      exp_fd    = ended;
      exp_valid = (q.size() > 0);
      exp_busy  = active;
    end
    cyc++;
  end

  always @(negedge in_clk) begin
    if (model_live) begin
      chk("m_valid", W'(out_valid), W'(exp_valid));
      chk("m_busy", W'(out_busy), W'(exp_busy));
      chk("m_overflow", W'(out_overflow), W'(exp_ov));
      chk("m_frame_done", W'(out_frame_done), W'(exp_fd));
      chk("m_data", out_data, shown);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic do_reset();
    in_rst   = 1'b1;
    in_valid = 1'b0;
    in_south = '0;
    step();
    step();
    in_rst = 1'b0;
  endtask

  // Row r, column c carries base + r*16 + c; lanes outside their valid slot get junk.
  task automatic send_rows(input int n, input logic [31:0] base, input int ready_k);
    for (int k = 0; k < n + COL - 1; k++) begin
      in_valid = (k < n);
      for (int c = 0; c < COL; c++) begin
        if (k - c >= 0 && k - c < n)
          in_south[(COL-1-c)*DW +: DW] = base + 32'((k - c) * 16 + c);
        else
          in_south[(COL-1-c)*DW +: DW] = 32'hDEAD0000 + 32'(k);
      end
      if (ready_k >= 0 && k >= ready_k) in_ready = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    in_rst   = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_south = '0;

    // 1: reset then idle
    do_reset();
    in_ready = 1'b1;
    repeat (10) step();
    @(negedge in_clk);
    chk("s1_valid", W'(out_valid), '0);
    chk("s1_busy", W'(out_busy), '0);
    chk("s1_overflow", W'(out_overflow), '0);
    chk("s1_data", out_data, '0);

    // 2: single row, latency COL
    do_reset();
    in_ready = 1'b1;
    send_rows(1, 32'h100, -1);
    @(negedge in_clk);
    chk("s2_valid", W'(out_valid), W'(1));
    chk("s2_data", out_data, 128'h00000100_00000101_00000102_00000103);

    // 3: full frame back-to-back
    do_reset();
    in_ready = 1'b1;
    send_rows(3, 32'h200, -1);
    @(negedge in_clk);
    chk("s3_row2", out_data, 128'h00000220_00000221_00000222_00000223);
    step();
    @(negedge in_clk);
    chk("s3_fd", W'(out_frame_done), W'(1));
    chk("s3_busy", W'(out_busy), '0);
    step();
    @(negedge in_clk);
    chk("s3_fd_off", W'(out_frame_done), '0);

    // 4: stalled downstream, third row dropped
    do_reset();
    in_ready = 1'b0;
    send_rows(3, 32'h300, -1);
    @(negedge in_clk);
    chk("s4_ov", W'(out_overflow), W'(1));
    chk("s4_head", out_data, 128'h00000300_00000301_00000302_00000303);
    in_ready = 1'b1;
    step();
    step();
    step();
    @(negedge in_clk);
    chk("s4_fd", W'(out_frame_done), W'(1));
    chk("s4_ov_sticky", W'(out_overflow), W'(1));
    chk("s4_hold", out_data, 128'h00000310_00000311_00000312_00000313);

    // 5: full FIFO with simultaneous push and pop
    do_reset();
    in_ready = 1'b0;
    send_rows(3, 32'h400, 5);
    @(negedge in_clk);
    chk("s5_ov", W'(out_overflow), '0);
    chk("s5_head", out_data, 128'h00000410_00000411_00000412_00000413);
    step();
    step();
    @(negedge in_clk);
    chk("s5_fd", W'(out_frame_done), W'(1));

    // 6: reset mid-fill, then a fresh frame
    do_reset();
    in_ready = 1'b0;
    send_rows(1, 32'h500, -1);
    @(negedge in_clk);
    chk("s6_busy_pre", W'(out_busy), W'(1));
    in_rst = 1'b1;
    step();
    @(negedge in_clk);
    chk("s6_valid", W'(out_valid), '0);
    chk("s6_busy", W'(out_busy), '0);
    chk("s6_fd", W'(out_frame_done), '0);
    in_rst   = 1'b0;
    in_ready = 1'b1;
    send_rows(3, 32'h600, -1);
    @(negedge in_clk);
    chk("s6_row2", out_data, 128'h00000620_00000621_00000622_00000623);
    step();
    @(negedge in_clk);
    chk("s6_fd2", W'(out_frame_done), W'(1));

    // 7: sustained burst longer than a frame, then drain
    do_reset();
    in_ready = 1'b1;
    send_rows(6, 32'h700, -1);
    repeat (12) step();

    // 8: slow downstream with a stalled start
    do_reset();
    in_ready = 1'b0;
    send_rows(3, 32'h800, 4);
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
